muldiv_unit: RTL and testbench

// - Parametrised iterative multiply/divide engine for the EX stage.
// - Handles MULT/MULTU/DIV/DIVU behind a single start/ready handshake.
// - Returns {HI,LO} for the HI/LO write path.
// - EX raises its stall request while an MD op is pending and ready_o is low.

---
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide engine (MULT/MULTU/DIV/DIVU) returning {HI,LO}.
// Optional build macro MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_W-1:0]     opa_i,
  input  logic [DATA_W-1:0]     opb_i,
  input  logic                  annul_i,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  div_zero_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [1:0]          op_r;
  logic [2*DATA_W-1:0] a_r;     // raw opa, then shifted multiplicand
  logic [DATA_W-1:0]   b_r;     // raw opb, then |multiplier| or |divisor|
  logic [2*DATA_W-1:0] acc_r;   // product, or {remainder, quotient}
  logic                sign_q_r;
  logic                sign_r_r;

  logic                is_div_s;
  logic                sa_s;
  logic                sb_s;
  logic [DATA_W-1:0]   abs_a_s;
  logic [DATA_W-1:0]   abs_b_s;
  logic [DATA_W:0]     rem_shift_s;
  logic [DATA_W:0]     diff_s;
  logic [2*DATA_W-1:0] div_next_s;
  logic                last_step_s;
  logic [DATA_W-1:0]   quot_s;
  logic [DATA_W-1:0]   rem_s;
  logic [2*DATA_W-1:0] fix_result_s;

  // Operand signs/magnitudes, restoring-divide step and final sign correction
  always_comb begin
    is_div_s     = op_r[1];
    sa_s         = ~op_r[0] & a_r[DATA_W-1];
    sb_s         = ~op_r[0] & b_r[DATA_W-1];
    abs_a_s      = a_r[DATA_W-1:0];
    abs_b_s      = b_r;
    if (sa_s) abs_a_s = -a_r[DATA_W-1:0];
    else      abs_a_s = a_r[DATA_W-1:0];
    if (sb_s) abs_b_s = -b_r;
    else      abs_b_s = b_r;

    rem_shift_s  = {acc_r[2*DATA_W-1:DATA_W], acc_r[DATA_W-1]};
    diff_s       = rem_shift_s - {1'b0, b_r};
    div_next_s   = acc_r;
    if (!diff_s[DATA_W]) div_next_s = {diff_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
    else                 div_next_s = {rem_shift_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};

    last_step_s  = (cnt_r == CNT_W'(DATA_W - 1)) ||
                   (EARLY_OUT && !is_div_s && (b_r[DATA_W-1:1] == {(DATA_W-1){1'b0}}));

    quot_s       = acc_r[DATA_W-1:0];
    rem_s        = acc_r[2*DATA_W-1:DATA_W];
    fix_result_s = acc_r;
    if (sign_q_r) quot_s = -acc_r[DATA_W-1:0];
    else          quot_s = acc_r[DATA_W-1:0];
    if (sign_r_r) rem_s = -acc_r[2*DATA_W-1:DATA_W];
    else          rem_s = acc_r[2*DATA_W-1:DATA_W];
    if (is_div_s)      fix_result_s = {rem_s, quot_s};
    else if (sign_q_r) fix_result_s = -acc_r;
    else               fix_result_s = acc_r;
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      op_r       <= 2'b00;
      a_r        <= '0;
      b_r        <= '0;
      acc_r      <= '0;
      sign_q_r   <= 1'b0;
      sign_r_r   <= 1'b0;
      busy_o     <= 1'b0;
      ready_o    <= 1'b0;
      result_o   <= '0;
      div_zero_o <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      if (annul_i && (state_r != ST_IDLE)) begin
        state_r <= ST_IDLE;
        busy_o  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            // annul in the same cycle drops the start
            if (start_i && !annul_i) begin
              op_r    <= op_i;
              a_r     <= {{DATA_W{1'b0}}, opa_i};
              b_r     <= opb_i;
              busy_o  <= 1'b1;
              state_r <= ST_PREP;
            end
          end
          ST_PREP: begin
            sign_q_r <= sa_s ^ sb_s;
            sign_r_r <= sa_s;
            cnt_r    <= '0;
            if (is_div_s && (b_r == {DATA_W{1'b0}})) begin
              result_o   <= {a_r[DATA_W-1:0], {DATA_W{1'b1}}};
              div_zero_o <= 1'b1;
              ready_o    <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
              b_r     <= abs_b_s;
              state_r <= ST_CALC;
              if (is_div_s) begin
                acc_r <= {{DATA_W{1'b0}}, abs_a_s};
              end else begin
                a_r   <= {{DATA_W{1'b0}}, abs_a_s};
                acc_r <= '0;
              end
            end
          end
          ST_CALC: begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (is_div_s) begin
              acc_r <= div_next_s;
            end else begin
              if (b_r[0]) acc_r <= acc_r + a_r;
              a_r <= a_r << 1;
              b_r <= b_r >> 1;
            end
            if (last_step_s) state_r <= ST_FIX;
          end
          ST_FIX: begin
            result_o   <= fix_result_s;
            div_zero_o <= 1'b0;
            ready_o    <= 1'b1;
            state_r    <= ST_DONE;
          end
          ST_DONE: begin
            busy_o  <= 1'b0;
            state_r <= ST_IDLE;
          end
          default: begin
            busy_o  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit (DATA_W=32) against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start_i;
  logic [1:0]    op_i;
  logic [W-1:0]  opa_i;
  logic [W-1:0]  opb_i;
  logic          annul_i;
  logic          busy_o;
  logic          ready_o;
  logic [2*W-1:0] result_o;
  logic          div_zero_o;

  int vectors = 0;
  int errors  = 0;

  muldiv_unit #(.DATA_W(W)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i),
    .opa_i(opa_i), .opb_i(opb_i), .annul_i(annul_i), .busy_o(busy_o),
    .ready_o(ready_o), .result_o(result_o), .div_zero_o(div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic plus the documented corner rules.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] res, output logic dz, output int lat);
    longint        sa, sb;
    longint unsigned ua, ub;
    int            si, sj;
    logic [31:0]   mag;
    int            iters;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    dz = 1'b0;
    res = 64'd0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFFFFFF};
          dz  = 1'b1;
        end else if (op == 2'b10 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          res = {32'd0, 32'h80000000};
        end else if (op == 2'b10) begin
          si = $signed(a);
          sj = $signed(b);
          res = {32'(si % sj), 32'(si / sj)};
        end else begin
          res = {a % b, a / b};
        end
      end
    endcase
    lat = 35;
    if (dz) lat = 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) begin
      mag = (op == 2'b00 && b[31]) ? -b : b;
      iters = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) iters = i + 1;
      lat = iters + 3;
    end
`else
    mag = b;
    iters = 0;
`endif
  endfunction

  // Issue one op, wait for ready_o, check result, flag and latency; ends one cycle after DONE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp_res;
    logic        exp_dz;
    int          exp_lat;
    int          cyc;
    model(op, a, b, exp_res, exp_dz, exp_lat);
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1;
    while (!ready_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_dz"}, {63'd0, div_zero_o}, {63'd0, exp_dz});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {62'd0, ready_o, busy_o}, 64'd0);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [63:0] old_res;
    logic [63:0] exp_res;
    logic        exp_dz;
    int          exp_lat;
    int          ready_cnt;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    resetn = 1'b0; start_i = 1'b0; op_i = 2'b00; opa_i = '0; opb_i = '0; annul_i = 1'b0;
    wait_cycles(3);
    check("reset", {busy_o, ready_o, div_zero_o, result_o}, 67'd0);
    resetn = 1'b1;
    wait_cycles(1);

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_const", result_o, 64'hFFFFFFFE_00000001);
    run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2);
    check("div_m7_2_const", result_o, 64'hFFFFFFFF_FFFFFFFD);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_const", result_o, 64'h00000000_80000000);
    run_op("divu_zero", 2'b11, 32'h1234, 32'd0);
    check("divu_zero_const", result_o, 64'h00001234_FFFFFFFF);
    run_op("div_zero", 2'b10, 32'h80000001, 32'd0);
    run_op("mult_5_3", 2'b00, 32'd5, 32'd3);
    check("mult_5_3_const", result_o, 64'h0000000F);

    // Annul in cycle 10 of a DIV
    old_res = result_o;
    start_i = 1'b1; op_i = 2'b10; opa_i = 32'd1000; opb_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_cycles(9);
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    check("annul_busy", {63'd0, busy_o}, 64'd0);
    ready_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) ready_cnt++;
      @(posedge clk); #1;
    end
    check("annul_noready", 64'(ready_cnt), 64'd0);
    check("annul_keep", result_o, old_res);
    run_op("mult_3_m4", 2'b00, 32'd3, 32'hFFFFFFFC);
    check("mult_3_m4_const", result_o, 64'hFFFFFFFF_FFFFFFF4);

    // Annul and start together in IDLE: start dropped
    annul_i = 1'b1; start_i = 1'b1; op_i = 2'b01; opa_i = 32'd9; opb_i = 32'd9;
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    check("annul_start", {63'd0, busy_o}, 64'd0);

    // Start pulsed in cycle 5 of a busy op is ignored
    model(2'b11, 32'd100, 32'd9, exp_res, exp_dz, exp_lat);
    start_i = 1'b1; op_i = 2'b11; opa_i = 32'd100; opb_i = 32'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_cycles(4);
    start_i = 1'b1; op_i = 2'b01; opa_i = 32'd7; opb_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    ready_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (ready_o) begin
        ready_cnt++;
        check("busy_start_res", result_o, exp_res);
      end
      @(posedge clk); #1;
    end
    check("busy_start_count", 64'(ready_cnt), 64'd1);

    // Reset low in cycle 20 of an op
    start_i = 1'b1; op_i = 2'b00; opa_i = 32'd12345; opb_i = 32'hFFFF0000;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_cycles(19);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midop_reset", {busy_o, ready_o, div_zero_o, result_o}, 67'd0);
    resetn = 1'b1;
    wait_cycles(1);

    // Randomized ops with corner-biased operands
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        3: rb = 32'($urandom_range(0, 15));
        default: ra = ra;
      endcase
      run_op("rand", rop, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
